// File: rtl/dac_adc_seq_ctrl.sv
// Debounced, release-triggered sequencer that launches DAC/ADC bursts one channel at a time.
// Optional per-launch handshake timeout is enabled by defining DAC_ADC_SEQ_TIMEOUT_EN.
module dac_adc_seq_ctrl #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned BURSTS          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          continuous,
    input  logic                          abort,
    input  logic [NUM_CH-1:0]             tx_done,
    input  logic [NUM_CH-1:0]             rx_done,
    output logic [NUM_CH-1:0]             begin_transmit,
    output logic [NUM_CH-1:0]             begin_receive,
    output logic                          busy,
    output logic                          run_done,
    output logic [$clog2(BURSTS+1)-1:0]   burst_idx,
    output logic [$clog2(NUM_CH+1)-1:0]   ch_idx,
    output logic                          timeout_err,
    output logic [$clog2(NUM_CH+1)-1:0]   err_ch
);
    localparam int unsigned BW = $clog2(BURSTS + 1);
    localparam int unsigned CW = $clog2(NUM_CH + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

    if (NUM_CH == 0 || BURSTS == 0 || DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES == 0)
    begin : g_param_check
        $error("dac_adc_seq_ctrl: NUM_CH, BURSTS, DEBOUNCE_CYCLES, TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {StIdle, StArmed, StLaunch, StWait, StGap} state_e;

    state_e            state_q;
    logic              start_meta_q, start_sync_q;
    logic [DW-1:0]     db_cnt_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              tx_flag_q, rx_flag_q, cont_q;
    logic [NUM_CH-1:0] ch_oh;
    logic              tx_hit, rx_hit, db_sat, ch_last, burst_last, timeout_hit;

    always_comb begin
        ch_oh      = NUM_CH'(1) << ch_idx;
        tx_hit     = |(tx_done & ch_oh);
        rx_hit     = |(rx_done & ch_oh);
        db_sat     = (db_cnt_q == DW'(DEBOUNCE_CYCLES));
        ch_last    = (ch_idx == CW'(NUM_CH - 1));
        burst_last = (burst_idx == BW'(BURSTS - 1));
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
        end else begin
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            db_cnt_q       <= '0;
            gap_cnt_q      <= '0;
            tx_flag_q      <= 1'b0;
            rx_flag_q      <= 1'b0;
            cont_q         <= 1'b0;
            begin_transmit <= '0;
            begin_receive  <= '0;
            busy           <= 1'b0;
            run_done       <= 1'b0;
            burst_idx      <= '0;
            ch_idx         <= '0;
        end else begin
            begin_transmit <= '0;
            begin_receive  <= '0;
            run_done       <= 1'b0;
            if (abort) begin
                state_q   <= StIdle;
                db_cnt_q  <= '0;
                gap_cnt_q <= '0;
                tx_flag_q <= 1'b0;
                rx_flag_q <= 1'b0;
                busy      <= 1'b0;
                burst_idx <= '0;
                ch_idx    <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        db_cnt_q <= start_sync_q ? DW'(1) : '0;
                        if (start_sync_q) state_q <= StArmed;
                    end
                    StArmed: begin
                        if (start_sync_q) begin
                            if (!db_sat) db_cnt_q <= db_cnt_q + 1'b1;
                        end else begin
                            // Launch fires on release, only after a fully debounced press.
                            db_cnt_q <= '0;
                            if (db_sat) begin
                                state_q        <= StLaunch;
                                begin_transmit <= ch_oh;
                                begin_receive  <= ch_oh;
                                busy           <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StLaunch: begin
                        tx_flag_q <= 1'b0;
                        rx_flag_q <= 1'b0;
                        if (ch_idx == '0 && burst_idx == '0) cont_q <= continuous;
                        state_q <= StWait;
                    end
                    StWait: begin
                        if ((tx_flag_q && rx_flag_q) || timeout_hit) begin
                            state_q   <= StGap;
                            gap_cnt_q <= '0;
                        end else begin
                            tx_flag_q <= tx_flag_q | tx_hit;
                            rx_flag_q <= rx_flag_q | rx_hit;
                        end
                    end
                    StGap: begin
                        if (gap_cnt_q != GW'(GAP_CYCLES)) begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end else if (!ch_last) begin
                            ch_idx         <= ch_idx + 1'b1;
                            begin_transmit <= ch_oh << 1;
                            begin_receive  <= ch_oh << 1;
                            state_q        <= StLaunch;
                        end else begin
                            ch_idx <= '0;
                            if (!burst_last || cont_q) begin
                                burst_idx      <= burst_last ? '0 : burst_idx + 1'b1;
                                begin_transmit <= NUM_CH'(1);
                                begin_receive  <= NUM_CH'(1);
                                state_q        <= StLaunch;
                            end else begin
                                burst_idx <= '0;
                                run_done  <= 1'b1;
                                busy      <= 1'b0;
                                state_q   <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef DAC_ADC_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q;

    assign timeout_hit = (state_q == StWait) && !(tx_flag_q && rx_flag_q) &&
                         (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
            err_ch      <= '0;
        end else if (abort) begin
            to_cnt_q <= '0;
        end else if (state_q == StLaunch) begin
            to_cnt_q <= '0;
            if (ch_idx == '0 && burst_idx == '0) begin
                timeout_err <= 1'b0;
                err_ch      <= '0;
            end
        end else if (state_q == StWait) begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                if (!timeout_err) err_ch <= ch_idx;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
    assign err_ch      = '0;
`endif

endmodule

// File: doc/dac_adc_seq_ctrl.md
# dac_adc_seq_ctrl

Parametrised successor to the single-shot DAC/ADC test trigger. It debounces the front-panel `start` button and runs a sequence of test bursts across `NUM_CH` converter channels, one channel at a time. For each channel it pulses `begin_transmit`/`begin_receive` and waits for per-channel done handshakes. It supports single-shot and continuous modes, abort, and an optional handshake timeout. It sits between the board button/switch inputs and the DAC transmit / ADC receive engines.

## Interface
- `NUM_CH`, 4: channel count, ≥1.
- `BURSTS`, 8: bursts per run (each burst visits every channel once), ≥1.
- `DEBOUNCE_CYCLES`, 500000: consecutive synchronised-high cycles `start` must hold before a release is accepted, ≥1.
- `GAP_CYCLES`, 16: idle cycles between channel launches, ≥0.
- `TIMEOUT_CYCLES`, 1000000: wait limit per launch; used only with the timeout feature.

Ports:
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low; deassertion synchronised externally.
- `start` in 1: raw asynchronous button, active-high.
- `continuous` in 1: sampled at launch of channel 0 / burst 0; 1 means wrap forever.
- `abort` in 1: synchronous, active-high.
- `tx_done` in `NUM_CH`: per-channel DAC completion, level or pulse.
- `rx_done` in `NUM_CH`: per-channel ADC completion, level or pulse.
- `begin_transmit` out `NUM_CH`: one-hot, one-cycle launch pulse.
- `begin_receive` out `NUM_CH`: one-hot, one-cycle launch pulse, coincident with `begin_transmit`.
- `busy` out 1: high in every state except IDLE/ARMED.
- `run_done` out 1: one-cycle pulse when a single-shot run completes.
- `burst_idx` out `$clog2(BURSTS+1)`: current burst.
- `ch_idx` out `$clog2(NUM_CH+1)`: current channel.
- `timeout_err` out 1: sticky error flag.
- `err_ch` out `$clog2(NUM_CH+1)`: channel of the first timeout.

## Operation
- `start` passes through a 2-flop synchroniser. Debounce counter counts consecutive high samples and saturates at `DEBOUNCE_CYCLES`; any low sample before saturation clears it.
- States:
  - IDLE → ARMED when the synchronised `start` is high.
  - ARMED → IDLE if `start` drops before the counter saturates. ARMED → LAUNCH on the first low sample after saturation (release-triggered, as in the previous generation).
  - LAUNCH, one cycle: assert bit `ch_idx` of both begin outputs, clear the done flags, latch `continuous` if `ch_idx`=0 and `burst_idx`=0. → WAIT.
  - WAIT: sticky flags capture `tx_done[ch_idx]` and `rx_done[ch_idx]` independently. Both may arrive in the same cycle or in separate cycles. When both flags are set → GAP. Done inputs for other channels are ignored.
  - GAP: count `GAP_CYCLES`, then advance. `ch_idx`+1; on wrap past `NUM_CH-1`, `ch_idx`=0 and `burst_idx`+1. On `burst_idx` wrap past `BURSTS-1`: if continuous is latched, go to LAUNCH with both indices 0; otherwise pulse `run_done` and → IDLE. With `GAP_CYCLES`=0, GAP lasts exactly one cycle.
- `abort` high in any state → IDLE next cycle. Indices and debounce counter clear; `timeout_err` is kept; no `run_done`.
- `start` activity while `busy` is ignored. The debounce counter is held at 0 until IDLE.
- `timeout_err` clears only on reset or on a new LAUNCH of channel 0 / burst 0.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, flags 0.
- `start` to first observable sample: 2 cycles of synchroniser latency.
- Release sample to `begin_*` pulse: 1 cycle.
- Done flag set (both captured) to GAP entry: 1 cycle. GAP exit to next LAUNCH: `GAP_CYCLES`+1 cycles total in GAP.
- A done input asserted during the LAUNCH cycle is not captured. Capture starts on the first WAIT cycle.
- `reset_n` low mid-run: outputs go to 0 immediately (asynchronous); no partial pulse persists.

## Configuration
- `DAC_ADC_SEQ_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs each time WAIT is entered.
  - On reaching `TIMEOUT_CYCLES` without both flags: set `timeout_err`, and load `err_ch` only if not already set.
  - Then → GAP and continue the sequence as normal.
- Not defined: WAIT has no limit. `timeout_err` and `err_ch` are tied 0, and the counter logic is absent.

## Test plan
- NUM_CH=2, BURSTS=3, DEBOUNCE=4, GAP=2, single-shot, start held 6 cycles then released, done returned 3 cycles after each launch:
  - 6 launches in order ch0,ch1 ×3.
  - `run_done` pulses once.
  - `busy` falls the same cycle as `run_done`.
- `start` held 3 cycles (less than DEBOUNCE=4) then released → no launch; state returns to IDLE.
- `tx_done` at WAIT+1 and `rx_done` at WAIT+5 → advance only after WAIT+5. Both in the same cycle → advance after 1 cycle. Done pulsed during the LAUNCH cycle → ignored.
- `continuous`=1 → after ch1/burst2 the next launch is ch0/burst0 with no `run_done`. `abort` then → IDLE next cycle, all indices 0.
- With `DAC_ADC_SEQ_TIMEOUT_EN` and TIMEOUT=16, ch1 never completes:
  - `timeout_err`=1 and `err_ch`=1 after 16 WAIT cycles.
  - The sequence continues.
  - `err_ch` is unchanged by a later ch0 timeout.
- `reset_n` dropped mid-WAIT → all outputs 0 asynchronously; after release, state is IDLE.
